// File: rtl/rs_alu_queue.sv
// rs_alu_queue: two-slot dispatch ALU reservation station with CDB wakeup and lowest-index select
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset (clears vld/rdy immediately)
//   i_kill                    flush: clears every entry at the next edge, overrides all else
//   i_dp_req[1:0], i_dp_*0/1  two dispatch slots (opcode, dst tag, per-source rdy/tag/data)
//   i_cdb_vld/tag/data        result broadcast used for wakeup and dispatch bypass
//   i_issue                   grant for the currently selected entry
//   o_allocable, o_free_cnt   free-entry status, from the vld vector only
//   o_sel_vld, o_sel_*        lowest-index ready entry, zero when none is ready
module rs_alu_queue #(
    parameter int ENTRY_NUM = 8,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_kill,
    input  logic [1:0]                   i_dp_req,
    input  logic [OP_W-1:0]              i_dp_op0,
    input  logic [TAG_W-1:0]             i_dp_dst0,
    input  logic                         i_dp_s1_rdy0,
    input  logic                         i_dp_s2_rdy0,
    input  logic [TAG_W-1:0]             i_dp_s1_tag0,
    input  logic [TAG_W-1:0]             i_dp_s2_tag0,
    input  logic [DATA_W-1:0]            i_dp_s1_data0,
    input  logic [DATA_W-1:0]            i_dp_s2_data0,
    input  logic [OP_W-1:0]              i_dp_op1,
    input  logic [TAG_W-1:0]             i_dp_dst1,
    input  logic                         i_dp_s1_rdy1,
    input  logic                         i_dp_s2_rdy1,
    input  logic [TAG_W-1:0]             i_dp_s1_tag1,
    input  logic [TAG_W-1:0]             i_dp_s2_tag1,
    input  logic [DATA_W-1:0]            i_dp_s1_data1,
    input  logic [DATA_W-1:0]            i_dp_s2_data1,
    input  logic                         i_cdb_vld,
    input  logic [TAG_W-1:0]             i_cdb_tag,
    input  logic [DATA_W-1:0]            i_cdb_data,
    input  logic                         i_issue,
    output logic                         o_allocable,
    output logic [$clog2(ENTRY_NUM):0]   o_free_cnt,
    output logic                         o_sel_vld,
    output logic [OP_W-1:0]              o_sel_op,
    output logic [TAG_W-1:0]             o_sel_dst,
    output logic [DATA_W-1:0]            o_sel_s1_data,
    output logic [DATA_W-1:0]            o_sel_s2_data
);
    localparam int IW = $clog2(ENTRY_NUM);

    logic [ENTRY_NUM-1:0] vld, s1_rdy, s2_rdy, ready;
    logic [OP_W-1:0]      op      [ENTRY_NUM];
    logic [TAG_W-1:0]     dst     [ENTRY_NUM];
    logic [TAG_W-1:0]     s1_tag  [ENTRY_NUM];
    logic [TAG_W-1:0]     s2_tag  [ENTRY_NUM];
    logic [DATA_W-1:0]    s1_data [ENTRY_NUM];
    logic [DATA_W-1:0]    s2_data [ENTRY_NUM];

    logic [1:0][OP_W-1:0]   d_op;
    logic [1:0][TAG_W-1:0]  d_dst, d_t1, d_t2;
    logic [1:0][DATA_W-1:0] d_v1, d_v2;
    logic [1:0]             d_r1, d_r2, byp1, byp2;
    logic [1:0][IW-1:0]     wr;

    logic [IW:0]   free_cnt;
    logic [IW-1:0] f0, f1, sel;
    logic          got0, got1, accept;

    assign d_op  = {i_dp_op1, i_dp_op0};
    assign d_dst = {i_dp_dst1, i_dp_dst0};
    assign d_t1  = {i_dp_s1_tag1, i_dp_s1_tag0};
    assign d_t2  = {i_dp_s2_tag1, i_dp_s2_tag0};
    assign d_v1  = {i_dp_s1_data1, i_dp_s1_data0};
    assign d_v2  = {i_dp_s2_data1, i_dp_s2_data0};
    assign d_r1  = {i_dp_s1_rdy1, i_dp_s1_rdy0};
    assign d_r2  = {i_dp_s2_rdy1, i_dp_s2_rdy0};

    // A not-ready source whose tag is on the CDB this cycle is written already woken.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            byp1[k] = !d_r1[k] && i_cdb_vld && d_t1[k] == i_cdb_tag;
            byp2[k] = !d_r2[k] && i_cdb_vld && d_t2[k] == i_cdb_tag;
        end
    end

    // Free count plus lowest and second-lowest free index, all from vld alone.
    always_comb begin
        free_cnt = '0;
        f0       = '0;
        f1       = '0;
        got0     = 1'b0;
        got1     = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!vld[i]) begin
                free_cnt = free_cnt + (IW+1)'(1);
                if (!got0) begin
                    f0   = IW'(i);
                    got0 = 1'b1;
                end else if (!got1) begin
                    f1   = IW'(i);
                    got1 = 1'b1;
                end
            end
        end
    end

    assign o_free_cnt  = free_cnt;
    assign o_allocable = free_cnt >= (IW+1)'(2);
    assign accept      = o_allocable && !i_kill;
    // Slot 1 alone takes the lowest free entry; with both slots it takes the second.
    assign wr[0]       = f0;
    assign wr[1]       = i_dp_req[0] ? f1 : f0;

    assign ready = vld & s1_rdy & s2_rdy;

    always_comb begin
        sel = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--)
            if (ready[i]) sel = IW'(i);
    end

    assign o_sel_vld     = |ready;
    assign o_sel_op      = o_sel_vld ? op[sel]      : '0;
    assign o_sel_dst     = o_sel_vld ? dst[sel]     : '0;
    assign o_sel_s1_data = o_sel_vld ? s1_data[sel] : '0;
    assign o_sel_s2_data = o_sel_vld ? s2_data[sel] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld    <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                op[i]      <= '0;
                dst[i]     <= '0;
                s1_tag[i]  <= '0;
                s2_tag[i]  <= '0;
                s1_data[i] <= '0;
                s2_data[i] <= '0;
            end
        end else if (i_kill) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (i_cdb_vld && vld[i] && !s1_rdy[i] && s1_tag[i] == i_cdb_tag) begin
                    s1_rdy[i]  <= 1'b1;
                    s1_data[i] <= i_cdb_data;
                end
                if (i_cdb_vld && vld[i] && !s2_rdy[i] && s2_tag[i] == i_cdb_tag) begin
                    s2_rdy[i]  <= 1'b1;
                    s2_data[i] <= i_cdb_data;
                end
            end
            // The issued entry is valid, so it never collides with a dispatch target.
            if (i_issue && o_sel_vld) vld[sel] <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (accept && i_dp_req[k]) begin
                    vld[wr[k]]     <= 1'b1;
                    op[wr[k]]      <= d_op[k];
                    dst[wr[k]]     <= d_dst[k];
                    s1_tag[wr[k]]  <= d_t1[k];
                    s2_tag[wr[k]]  <= d_t2[k];
                    s1_rdy[wr[k]]  <= d_r1[k] | byp1[k];
                    s2_rdy[wr[k]]  <= d_r2[k] | byp2[k];
                    s1_data[wr[k]] <= byp1[k] ? i_cdb_data : d_v1[k];
                    s2_data[wr[k]] <= byp2[k] ? i_cdb_data : d_v2[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_alu_queue.sv
// tb_rs_alu_queue: self-checking bench for rs_alu_queue (vector table plus directed corner sequences)
module tb_rs_alu_queue;
    logic        i_clk = 1'b0, i_rst_n, i_kill, i_issue, i_cdb_vld;
    logic [1:0]  i_dp_req;
    logic [3:0]  i_dp_op0, i_dp_op1;
    logic [5:0]  i_dp_dst0, i_dp_dst1, i_dp_s1_tag0, i_dp_s2_tag0, i_dp_s1_tag1, i_dp_s2_tag1, i_cdb_tag;
    logic        i_dp_s1_rdy0, i_dp_s2_rdy0, i_dp_s1_rdy1, i_dp_s2_rdy1;
    logic [31:0] i_dp_s1_data0, i_dp_s2_data0, i_dp_s1_data1, i_dp_s2_data1, i_cdb_data;
    logic        o_allocable, o_sel_vld;
    logic [3:0]  o_free_cnt, o_sel_op;
    logic [5:0]  o_sel_dst;
    logic [31:0] o_sel_s1_data, o_sel_s2_data;

    rs_alu_queue dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_kill(i_kill), .i_dp_req(i_dp_req),
        .i_dp_op0(i_dp_op0), .i_dp_dst0(i_dp_dst0),
        .i_dp_s1_rdy0(i_dp_s1_rdy0), .i_dp_s2_rdy0(i_dp_s2_rdy0),
        .i_dp_s1_tag0(i_dp_s1_tag0), .i_dp_s2_tag0(i_dp_s2_tag0),
        .i_dp_s1_data0(i_dp_s1_data0), .i_dp_s2_data0(i_dp_s2_data0),
        .i_dp_op1(i_dp_op1), .i_dp_dst1(i_dp_dst1),
        .i_dp_s1_rdy1(i_dp_s1_rdy1), .i_dp_s2_rdy1(i_dp_s2_rdy1),
        .i_dp_s1_tag1(i_dp_s1_tag1), .i_dp_s2_tag1(i_dp_s2_tag1),
        .i_dp_s1_data1(i_dp_s1_data1), .i_dp_s2_data1(i_dp_s2_data1),
        .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .i_issue(i_issue), .o_allocable(o_allocable), .o_free_cnt(o_free_cnt),
        .o_sel_vld(o_sel_vld), .o_sel_op(o_sel_op), .o_sel_dst(o_sel_dst),
        .o_sel_s1_data(o_sel_s1_data), .o_sel_s2_data(o_sel_s2_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  dst;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    typedef struct {
        int          slot;
        logic [3:0]  op;
        logic [5:0]  dst;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] d1;
        logic        r2;
        logic [5:0]  t2;
        logic [31:0] d2;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        e_rdy;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr();
        {i_kill, i_issue, i_cdb_vld, i_dp_req, i_cdb_tag, i_cdb_data} = '0;
        {i_dp_op0, i_dp_dst0, i_dp_s1_rdy0, i_dp_s2_rdy0, i_dp_s1_tag0, i_dp_s2_tag0, i_dp_s1_data0, i_dp_s2_data0} = '0;
        {i_dp_op1, i_dp_dst1, i_dp_s1_rdy1, i_dp_s2_rdy1, i_dp_s1_tag1, i_dp_s2_tag1, i_dp_s1_data1, i_dp_s2_data1} = '0;
    endtask

    task automatic set_slot(input int k, input logic [3:0] op, input logic [5:0] dst,
                            input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] d2);
        if (k == 0) begin
            i_dp_op0 = op; i_dp_dst0 = dst;
            i_dp_s1_rdy0 = r1; i_dp_s1_tag0 = t1; i_dp_s1_data0 = d1;
            i_dp_s2_rdy0 = r2; i_dp_s2_tag0 = t2; i_dp_s2_data0 = d2;
        end else begin
            i_dp_op1 = op; i_dp_dst1 = dst;
            i_dp_s1_rdy1 = r1; i_dp_s1_tag1 = t1; i_dp_s1_data1 = d1;
            i_dp_s2_rdy1 = r2; i_dp_s2_tag1 = t2; i_dp_s2_data1 = d2;
        end
    endtask

    // Ready dispatch whose expected issue record goes straight into the scoreboard.
    task automatic disp_rdy(input int k, input logic [3:0] op, input logic [5:0] dst,
                            input logic [31:0] d1, input logic [31:0] d2);
        set_slot(k, op, dst, 1'b1, 6'h00, d1, 1'b1, 6'h00, d2);
        sbq.push_back('{op, dst, d1, d2});
    endtask

    task automatic cmp_front(input string nm);
        exp_t e;
        e = sbq.pop_front();
        chk({nm, "_op"}, 64'(o_sel_op), 64'(e.op));
        chk({nm, "_dst"}, 64'(o_sel_dst), 64'(e.dst));
        chk({nm, "_s1"}, 64'(o_sel_s1_data), 64'(e.d1));
        chk({nm, "_s2"}, 64'(o_sel_s2_data), 64'(e.d2));
    endtask

    // Issue every selected entry, comparing it against the scoreboard head.
    task automatic drain(input string nm, input int budget);
        int c;
        c = 0;
        while (sbq.size() > 0 && c < budget) begin
            if (o_sel_vld) begin
                cmp_front(nm);
                i_issue = 1'b1;
            end
            step();
            i_issue = 1'b0;
            c++;
        end
        if (sbq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d entries never selected, expected 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{0, 4'h1, 6'h01, 1'b1, 6'h00, 32'h11111111, 1'b1, 6'h00, 32'h22222222, 1'b0, 6'h00, 32'h0, 1'b1, 32'h11111111, 32'h22222222};
        vt[1] = '{0, 4'h2, 6'h02, 1'b1, 6'h00, 32'h00000042, 1'b0, 6'h0A, 32'h0, 1'b1, 6'h0A, 32'hCAFEF00D, 1'b1, 32'h00000042, 32'hCAFEF00D};
        vt[2] = '{1, 4'h3, 6'h03, 1'b0, 6'h05, 32'h0, 1'b1, 6'h00, 32'h7, 1'b1, 6'h06, 32'h99, 1'b0, 32'h0, 32'h0};
        vt[3] = '{0, 4'h4, 6'h04, 1'b0, 6'h07, 32'h0, 1'b1, 6'h00, 32'h8, 1'b0, 6'h07, 32'h55, 1'b0, 32'h0, 32'h0};
        vt[4] = '{1, 4'h5, 6'h05, 1'b0, 6'h03, 32'h0, 1'b0, 6'h03, 32'h0, 1'b1, 6'h03, 32'h33333333, 1'b1, 32'h33333333, 32'h33333333};
        vt[5] = '{0, 4'h6, 6'h06, 1'b1, 6'h09, 32'h00001234, 1'b1, 6'h09, 32'h00005678, 1'b1, 6'h09, 32'h99999999, 1'b1, 32'h00001234, 32'h00005678};
        vt[6] = '{1, 4'hF, 6'h3F, 1'b1, 6'h00, 32'hFFFFFFFF, 1'b1, 6'h00, 32'hFFFFFFFF, 1'b0, 6'h00, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};

        clr();
        i_rst_n = 1'b0;
        step();
        step();
        chk("rst_alloc", 64'(o_allocable), 64'd1);
        chk("rst_free", 64'(o_free_cnt), 64'd8);
        chk("rst_sel_vld", 64'(o_sel_vld), 64'd0);
        chk("rst_sel_dst", 64'(o_sel_dst), 64'd0);
        #3 i_rst_n = 1'b1;
        step();

        // Two-slot dispatch into the empty queue.
        disp_rdy(0, 4'h3, 6'h10, 32'hA0A0A0A0, 32'hB0B0B0B0);
        disp_rdy(1, 4'h5, 6'h11, 32'hC0C0C0C0, 32'hD0D0D0D0);
        i_dp_req = 2'b11;
        step();
        clr();
        chk("dual_free", 64'(o_free_cnt), 64'd6);
        chk("dual_sel_vld", 64'(o_sel_vld), 64'd1);
        drain("dual", 10);
        chk("dual_empty", 64'(o_free_cnt), 64'd8);

        // Table of single dispatches, some with same-cycle CDB traffic.
        foreach (vt[i]) begin
            set_slot(vt[i].slot, vt[i].op, vt[i].dst, vt[i].r1, vt[i].t1, vt[i].d1, vt[i].r2, vt[i].t2, vt[i].d2);
            i_dp_req   = vt[i].slot == 0 ? 2'b01 : 2'b10;
            i_cdb_vld  = vt[i].cv;
            i_cdb_tag  = vt[i].ct;
            i_cdb_data = vt[i].cd;
            step();
            clr();
            chk($sformatf("vec%0d_rdy", i), 64'(o_sel_vld), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_free", i), 64'(o_free_cnt), 64'd7);
            if (vt[i].e_rdy) begin
                sbq.push_back('{vt[i].op, vt[i].dst, vt[i].e1, vt[i].e2});
                drain($sformatf("vec%0d", i), 5);
            end else begin
                i_kill = 1'b1;
                step();
                clr();
            end
            chk($sformatf("vec%0d_empty", i), 64'(o_free_cnt), 64'd8);
        end

        // Wakeup two cycles after dispatch; select only the cycle after the broadcast.
        set_slot(0, 4'h7, 6'h20, 1'b0, 6'h05, 32'h0, 1'b1, 6'h00, 32'h00000077);
        i_dp_req = 2'b01;
        step();
        clr();
        chk("wake_wait1", 64'(o_sel_vld), 64'd0);
        step();
        chk("wake_wait2", 64'(o_sel_vld), 64'd0);
        i_cdb_vld = 1'b1; i_cdb_tag = 6'h05; i_cdb_data = 32'hDEADBEEF;
        #1 chk("wake_no_fwd", 64'(o_sel_vld), 64'd0);
        step();
        clr();
        chk("wake_sel_vld", 64'(o_sel_vld), 64'd1);
        sbq.push_back('{4'h7, 6'h20, 32'hDEADBEEF, 32'h00000077});
        drain("wake", 5);
        i_cdb_vld = 1'b1; i_cdb_tag = 6'h05; i_cdb_data = 32'h12345678;
        step();
        clr();
        chk("cdb_invalid_sel", 64'(o_sel_vld), 64'd0);
        chk("cdb_invalid_free", 64'(o_free_cnt), 64'd8);

        // Fill to seven, reject an eighth and ninth, then issue at the boundary.
        for (int p = 0; p < 3; p++) begin
            disp_rdy(0, 4'(p), 6'(2 * p), 32'h100 + 32'(2 * p), 32'h200 + 32'(2 * p));
            disp_rdy(1, 4'(p + 8), 6'(2 * p + 1), 32'h100 + 32'(2 * p + 1), 32'h200 + 32'(2 * p + 1));
            i_dp_req = 2'b11;
            step();
        end
        clr();
        disp_rdy(0, 4'h9, 6'h06, 32'h106, 32'h206);
        i_dp_req = 2'b01;
        step();
        clr();
        chk("full_free", 64'(o_free_cnt), 64'd1);
        chk("full_alloc", 64'(o_allocable), 64'd0);
        set_slot(0, 4'hE, 6'h30, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1);
        set_slot(1, 4'hE, 6'h31, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1);
        i_dp_req = 2'b11;
        step();
        clr();
        chk("full_ignored", 64'(o_free_cnt), 64'd1);
        cmp_front("full_issue");
        i_issue = 1'b1;
        step();
        clr();
        chk("after_issue_free", 64'(o_free_cnt), 64'd2);
        chk("after_issue_alloc", 64'(o_allocable), 64'd1);
        // Issue and a two-slot dispatch together; the new entries wait on a tag.
        cmp_front("co_issue");
        set_slot(0, 4'hA, 6'h2A, 1'b0, 6'h20, 32'h0, 1'b1, 6'h00, 32'h0);
        set_slot(1, 4'hB, 6'h2B, 1'b0, 6'h20, 32'h0, 1'b1, 6'h00, 32'h0);
        i_dp_req = 2'b11;
        i_issue  = 1'b1;
        step();
        clr();
        chk("co_issue_free", 64'(o_free_cnt), 64'd1);
        drain("tail", 20);
        chk("tail_free", 64'(o_free_cnt), 64'd6);
        i_kill = 1'b1;
        step();
        clr();
        chk("tail_kill", 64'(o_free_cnt), 64'd8);

        // Kill overrides dispatch, issue and wakeup in the same cycle.
        set_slot(0, 4'h1, 6'h21, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 32'h2);
        set_slot(1, 4'h2, 6'h22, 1'b1, 6'h00, 32'h3, 1'b1, 6'h00, 32'h4);
        i_dp_req = 2'b11;
        step();
        set_slot(0, 4'h3, 6'h23, 1'b1, 6'h00, 32'h5, 1'b1, 6'h00, 32'h6);
        set_slot(1, 4'h4, 6'h24, 1'b0, 6'h11, 32'h0, 1'b1, 6'h00, 32'h8);
        step();
        chk("kill_pre_free", 64'(o_free_cnt), 64'd4);
        i_kill = 1'b1; i_issue = 1'b1;
        i_cdb_vld = 1'b1; i_cdb_tag = 6'h11; i_cdb_data = 32'hABCD;
        step();
        clr();
        chk("kill_free", 64'(o_free_cnt), 64'd8);
        chk("kill_sel_vld", 64'(o_sel_vld), 64'd0);
        chk("kill_alloc", 64'(o_allocable), 64'd1);

        // Asynchronous reset between edges with three entries pending.
        set_slot(0, 4'h1, 6'h01, 1'b1, 6'h00, 32'h1, 1'b1, 6'h00, 32'h1);
        set_slot(1, 4'h2, 6'h02, 1'b1, 6'h00, 32'h2, 1'b1, 6'h00, 32'h2);
        i_dp_req = 2'b11;
        step();
        i_dp_req = 2'b01;
        step();
        clr();
        chk("ar_pre_free", 64'(o_free_cnt), 64'd5);
        #3 i_rst_n = 1'b0;
        #1;
        chk("ar_free", 64'(o_free_cnt), 64'd8);
        chk("ar_alloc", 64'(o_allocable), 64'd1);
        chk("ar_sel_vld", 64'(o_sel_vld), 64'd0);
        chk("ar_sel_op", 64'(o_sel_op), 64'd0);
        chk("ar_sel_s1", 64'(o_sel_s1_data), 64'd0);
        chk("ar_sel_s2", 64'(o_sel_s2_data), 64'd0);
        @(posedge i_clk);
        #4 i_rst_n = 1'b1;
        // X waits on a tag; Y is ready. Once X wakes it must outrank Y, i.e. sit in entry 0.
        set_slot(1, 4'h8, 6'h38, 1'b0, 6'h15, 32'h0, 1'b1, 6'h00, 32'h00000808);
        i_dp_req = 2'b10;
        step();
        clr();
        set_slot(0, 4'h9, 6'h39, 1'b1, 6'h00, 32'h00000909, 1'b1, 6'h00, 32'h00000A0A);
        i_dp_req = 2'b01;
        step();
        clr();
        chk("ar_y_sel", 64'(o_sel_dst), 64'h39);
        i_cdb_vld = 1'b1; i_cdb_tag = 6'h15; i_cdb_data = 32'h15151515;
        step();
        clr();
        sbq.push_back('{4'h8, 6'h38, 32'h15151515, 32'h00000808});
        sbq.push_back('{4'h9, 6'h39, 32'h00000909, 32'h00000A0A});
        drain("ar", 10);
        chk("ar_empty", 64'(o_free_cnt), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_alu_queue.md
RS_ALU_QUEUE -- requirements
Module: rs_alu_queue

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, meaning the number of reservation-station entries (power of two, ≥4).
REQ-002 SHALL have parameter TAG_W, default 6, meaning the physical-register tag width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the operand width.
REQ-004 SHALL have parameter OP_W, default 4, meaning the ALU opcode width.
REQ-005 SHALL have ports as follows:
- i_clk  in  1  -- the single clock; all state updates on its rising edge.
- i_rst_n  in  1  -- reset, asynchronous and active-low.
- i_kill  in  1  -- pipeline flush on a branch mispredict.
- i_dp_req  in  2  -- dispatch request; bit k is dispatch slot k.
- For each slot k in {0,1}:
  - i_dp_opK  in  OP_W  -- opcode.
  - i_dp_dstK  in  TAG_W  -- destination tag.
  - i_dp_s1_rdyK / i_dp_s2_rdyK  in  1  -- source operand already valid.
  - i_dp_s1_tagK / i_dp_s2_tagK  in  TAG_W  -- source tag.
  - i_dp_s1_dataK / i_dp_s2_dataK  in  DATA_W  -- source value, meaningful only when ready.
- i_cdb_vld, i_cdb_tag, i_cdb_data  in  1/TAG_W/DATA_W  -- result broadcast bus.
- i_issue  in  1  -- the issue grant, equal to the selected-valid signal ANDed with execution-unit accessibility.
- o_allocable  out  1  -- at least 2 entries are free.
- o_free_cnt  out  log2(ENTRY_NUM)+1  -- number of free entries.
- o_sel_vld  out  1  -- at least one entry is ready to issue.
- o_sel_op, o_sel_dst, o_sel_s1_data, o_sel_s2_data  out  OP_W/TAG_W/DATA_W/DATA_W  -- fields of the selected entry.

Function
REQ-006 SHALL hold, per entry, the following registered fields: vld, op, dst, and for each source a rdy bit, a tag and a data value.
REQ-007 o_allocable and o_free_cnt SHALL be combinational from the current vld vector only, and SHALL NOT depend on the same-cycle i_issue or i_dp_req.
REQ-008 Dispatch SHALL be accepted when o_allocable=1 and i_kill=0.
- Slot 0 writes the lowest-index free entry.
- Slot 1 writes the second-lowest free entry.
- If only slot 1 requests, it writes the lowest-index free entry.
REQ-009 When o_allocable=0 or i_kill=1, i_dp_req SHALL be ignored and no entry SHALL be written.
REQ-010 A dispatched entry SHALL become valid at the rising edge following the request.
REQ-011 Wakeup: when i_cdb_vld=1, every valid entry whose not-ready source tag equals i_cdb_tag SHALL set that source's rdy and capture i_cdb_data at the edge.
REQ-012 Dispatch bypass: if a dispatched source is not ready and its tag equals the same-cycle i_cdb_tag with i_cdb_vld=1, the entry SHALL be written ready with i_cdb_data.
REQ-013 An entry is ready when vld=1 and both source rdy bits are 1.
- o_sel_vld SHALL be 1 when any entry is ready.
- Selection SHALL pick the lowest-index ready entry.
- The o_sel_* outputs SHALL present that entry's fields combinationally.
REQ-014 Issue latency: an entry woken at edge N SHALL be selectable in cycle N, i.e. the cycle after the CDB broadcast.
- There SHALL be no same-cycle CDB-to-select forwarding.
REQ-015 When i_issue=1 and o_sel_vld=1, the selected entry's vld SHALL clear at the next edge.
- i_issue=1 while o_sel_vld=0 SHALL have no effect.
REQ-016 An entry freed by issue SHALL NOT be reallocated in the same cycle.
- Simultaneous issue and dispatch SHALL both take effect, touching different entries.
REQ-017 When i_kill=1, all vld bits SHALL clear at the next edge.
- Kill SHALL take priority over dispatch, issue and wakeup in that cycle.
REQ-018 A CDB match on an invalid entry SHALL change no observable output.
REQ-019 Entry contents other than vld SHALL be don't-care while vld=0.

Reset
REQ-020 Asserting i_rst_n=0 SHALL immediately clear all vld and rdy bits, without waiting for a clock edge.
REQ-021 While in reset, outputs SHALL be:
- o_allocable=1.
- o_free_cnt=ENTRY_NUM.
- o_sel_vld=0.
- o_sel_* = 0.
REQ-022 Reset asserted mid-operation SHALL discard all pending entries.
- The first dispatch after deassertion SHALL write entry 0.

Verification
REQ-023 Two-slot dispatch into empty queue:
- Stimulus: dispatch both slots, all sources ready.
- Required: next cycle entries 0 and 1 valid, o_free_cnt=6, o_sel_vld=1, selected entry is entry 0.
REQ-024 Wakeup:
- Stimulus: dispatch slot 0 with s1 not ready (tag 0x05); two cycles later broadcast i_cdb_vld=1, tag 0x05, data 0xDEADBEEF.
- Required: o_sel_vld rises the cycle after the broadcast, and o_sel_s1_data=0xDEADBEEF.
REQ-025 Dispatch bypass:
- Stimulus: dispatch with s2 tag 0x0A not ready while the CDB broadcasts tag 0x0A in the same cycle.
- Required: entry is ready next cycle and o_sel_s2_data equals the CDB data.
REQ-026 Full and boundary:
- Stimulus: fill to 7 entries.
- Required: o_allocable=0; a further request is ignored and o_free_cnt stays 1.
- Stimulus: issue once.
- Required: o_free_cnt=2 next cycle and o_allocable=1.
REQ-027 Kill priority:
- Stimulus: with 4 entries valid, assert i_kill together with dispatch, i_issue and a CDB match.
- Required: next cycle o_free_cnt=8, o_sel_vld=0.
REQ-028 Asynchronous reset:
- Stimulus: drop i_rst_n between clock edges while 3 entries are valid.
- Required: outputs reach their reset values before the next edge; after release, a dispatch lands in entry 0.
